// File: rtl/ser_pkg.sv
// Shared types and constants for the bit serializer.
package ser_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } ser_state_t;

  localparam int unsigned DEFAULT_WIDTH = 8;

endpackage : ser_pkg

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a valid/ready accept port.
// Optional even-parity trailer bit when BIT_SERIALIZER_PARITY_EN is defined.
module bit_serializer
  import ser_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int unsigned     CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);

  ser_state_t       state_q, state_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             busy_q, busy_d;
  // Holds din_ready low until the first clock edge after reset release.
  logic             ready_en_q;
  logic             accept;
`ifdef BIT_SERIALIZER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  // Ready depends only on registered state: idle, or the last bit of a frame.
  always_comb begin
    din_ready = 1'b0;
    if (ready_en_q) begin
      case (state_q)
        IDLE:    din_ready = 1'b1;
`ifdef BIT_SERIALIZER_PARITY_EN
        PARITY:  din_ready = 1'b1;
`else
        DATA:    din_ready = (bit_cnt_q == LAST_CNT);
`endif
        default: din_ready = 1'b0;
      endcase
    end
  end

  assign accept = din_valid && din_ready;

  // Next-state, shift and counter logic; outputs are derived from the next
  // values so that the registered outputs line up with the new state.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
`ifdef BIT_SERIALIZER_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      DATA: begin
        if (bit_cnt_q != LAST_CNT) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          shreg_d   = (MSB_FIRST != 0) ? {shreg_q[WIDTH-2:0], 1'b0}
                                       : {1'b0, shreg_q[WIDTH-1:1]};
        end else begin
`ifdef BIT_SERIALIZER_PARITY_EN
          state_d = PARITY;
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef BIT_SERIALIZER_PARITY_EN
      PARITY:  state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
    // A same-edge accept (from IDLE or the final bit) overrides the above.
    if (accept) begin
      state_d   = DATA;
      bit_cnt_d = '0;
      shreg_d   = din;
`ifdef BIT_SERIALIZER_PARITY_EN
      parity_d  = ^din;
`endif
    end

    ser_valid_d   = (state_d != IDLE);
    busy_d        = (state_d != IDLE);
    frame_start_d = (state_d == DATA) && (bit_cnt_d == '0);
    ser_out_d     = 1'b0;
    if (state_d == DATA) begin
      ser_out_d = (MSB_FIRST != 0) ? shreg_d[WIDTH-1] : shreg_d[0];
    end
`ifdef BIT_SERIALIZER_PARITY_EN
    else if (state_d == PARITY) begin
      ser_out_d = parity_d;
    end
`endif
  end

  // FSM state, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      shreg_q       <= '0;
      ser_out_q     <= 1'b0;
      ser_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
      ready_en_q    <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
      parity_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shreg_q       <= shreg_d;
      ser_out_q     <= ser_out_d;
      ser_valid_q   <= ser_valid_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
      ready_en_q    <= 1'b1;
`ifdef BIT_SERIALIZER_PARITY_EN
      parity_q      <= parity_d;
`endif
    end
  end

  assign ser_out     = ser_out_q;
  assign ser_valid   = ser_valid_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;

endmodule : bit_serializer
